bram_fifo: RTL and testbench
============================

BRAM_FIFO -- requirements
Module: bram_fifo

Interface
REQ-001 The block SHALL have parameter memSize_p, default 6, meaning log2 of FIFO depth (depth = 2**memSize_p words).
REQ-002 The block SHALL have parameter XLEN, default 32, meaning data word width in bits.
REQ-003 The block SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port wr_valid_i  input  1  producer offers wr_data_i.
REQ-006 The block SHALL have port wr_ready_o  output  1  FIFO can accept a word this cycle.
REQ-007 The block SHALL have port wr_data_i  input  XLEN  write data.
REQ-008 The block SHALL have port rd_valid_o  output  1  rd_data_o holds the oldest unconsumed word.
REQ-009 The block SHALL have port rd_ready_i  input  1  consumer takes rd_data_o this cycle.
REQ-010 The block SHALL have port rd_data_o  output  XLEN  head-of-queue data, registered.
REQ-011 The block SHALL have port count_o  output  memSize_p+1  number of accepted, not yet consumed words.
REQ-012 The block SHALL have ports full_o and empty_o  output  1 each  count_o == 2**memSize_p, count_o == 0.

Function
REQ-013 Storage SHALL be one instance of bram_dual_re (memSize_p, XLEN), with 1-cycle read latency and same-address write-through.
REQ-014 Push SHALL occur on an edge where wr_valid_i && wr_ready_o; pop SHALL occur on an edge where rd_valid_o && rd_ready_i.
REQ-015 wr_ready_o SHALL equal !full_o && !reset_i and SHALL NOT depend on rd_ready_i.
REQ-016 Write pointer and read pointer SHALL be memSize_p bits and wrap from 2**memSize_p-1 to 0 silently.
REQ-017 count_o SHALL increment on push only, decrement on pop only, and be unchanged on simultaneous push and pop.
REQ-018 count_o SHALL include words in RAM, in the RAM read stage, and in the output register.
REQ-019 The output stage SHALL be a 3-state machine: EMPTY (no head word), PEND (RAM read issued, data arrives next edge), VALID (rd_data_o loaded, rd_valid_o = 1).
REQ-020 A RAM read SHALL be issued (read_i = 1, raddr_i = read pointer, pointer + 1) when at least one unread word exists in RAM or is being pushed this cycle, and the state is EMPTY, or VALID with a pop this edge.
REQ-021 Transitions SHALL be: EMPTY -> PEND on read issue; PEND -> VALID unconditionally, loading RAM data_o; VALID -> PEND on pop with read issue; VALID -> EMPTY on pop with no read issue; otherwise hold.
REQ-022 Push into an empty FIFO at edge k SHALL use RAM write-through so that rd_valid_o = 1 with that word after edge k+1.
REQ-023 rd_data_o and rd_valid_o SHALL not change while rd_valid_o && !rd_ready_i.
REQ-024 Words SHALL be delivered in push order with no loss or duplication across pointer wrap.
REQ-025 Push when full SHALL be impossible (wr_ready_o = 0); a simultaneous pop at full SHALL free a slot only from the next cycle.
REQ-026 rd_valid_o SHALL be 0 in EMPTY and PEND states.

Reset
REQ-027 While reset_i = 1 at an edge, pointers SHALL clear to 0, count_o to 0, and state to EMPTY, and any push or pop that edge SHALL be discarded.
REQ-028 After reset, rd_valid_o = 0, rd_data_o = 0, empty_o = 1, full_o = 0, and wr_ready_o = 1 once reset_i is low.
REQ-029 Reset mid-operation SHALL drop all queued words; RAM contents need not clear.

Verification (memSize_p = 2, XLEN = 32)
REQ-030 Single push 0xA5A5_0001 at edge k into empty FIFO, rd_ready_i = 0 -> rd_valid_o = 1 with that data after edge k+1; count_o = 1 and holds.
REQ-031 Push 4 words 1..4 with rd_ready_i = 0 -> full_o = 1, wr_ready_o = 0, count_o = 4; a fifth wr_valid_i is not accepted; then drain -> data 1,2,3,4 in order.
REQ-032 Continuous push and pop with rd_ready_i = 1 for 10 words 0x10..0x19 -> all delivered in order across pointer wrap, count_o never exceeds 2.
REQ-033 At full, hold rd_ready_i = 1 and wr_valid_i = 1 for one edge -> pop occurs, no push, count_o = 3; the push is accepted the next edge.
REQ-034 Random rd_ready_i stalls -> rd_data_o stable while rd_valid_o && !rd_ready_i; scoreboard matches.
REQ-035 Assert reset_i for one edge with count_o = 3 -> count_o = 0, rd_valid_o = 0, empty_o = 1; the next push 0x55 is the first word read.

Source files
------------

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO on a 1-cycle-latency dual-port RAM.
// A 3-state output stage (EMPTY/PEND/VALID) hides the RAM latency behind a registered head word.

module bram_dual_re #(
  parameter int memSize_p = 6,
  parameter int XLEN      = 32
) (
  input  logic                 clk_i,
  input  logic                 write_i,
  input  logic [memSize_p-1:0] waddr_i,
  input  logic [XLEN-1:0]      wdata_i,
  input  logic                 read_i,
  input  logic [memSize_p-1:0] raddr_i,
  output logic [XLEN-1:0]      data_o
);
  logic [XLEN-1:0] mem [2**memSize_p];
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] data_d;

  // Same-address read returns the word being written this edge.
  always_comb begin
    data_d = data_q;
    if (read_i) begin
      if (write_i && (waddr_i == raddr_i)) data_d = wdata_i;
      else                                 data_d = mem[raddr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (write_i) mem[waddr_i] <= wdata_i;
    data_q <= data_d;
  end

  assign data_o = data_q;
endmodule

module bram_fifo #(
  parameter int memSize_p = 6,
  parameter int XLEN      = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [XLEN-1:0]      wr_data_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [XLEN-1:0]      rd_data_o,
  output logic [memSize_p:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);
  localparam logic [memSize_p:0] FULL_CNT = (memSize_p+1)'(2**memSize_p);

  typedef enum logic [1:0] {ST_EMPTY, ST_PEND, ST_VALID} state_e;

  state_e                 state_q, state_d;
  logic [memSize_p-1:0]   wptr_q, wptr_d;
  logic [memSize_p-1:0]   rptr_q, rptr_d;
  logic [memSize_p:0]     count_q, count_d;
  logic [XLEN-1:0]        rd_data_q, rd_data_d;

  logic                   push;
  logic                   pop;
  logic                   rd_issue;
  logic [memSize_p:0]     unread;
  logic [XLEN-1:0]        ram_data;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign wr_ready_o = !full_o && !reset_i;
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = rd_valid_o && rd_ready_i;
  assign count_o    = count_q;
  assign rd_data_o  = rd_data_q;

  // Words still in RAM = total minus the one held by PEND or VALID.
  assign unread = count_q - {{memSize_p{1'b0}}, (state_q != ST_EMPTY)};

  bram_dual_re #(
    .memSize_p (memSize_p),
    .XLEN      (XLEN)
  ) u_ram (
    .clk_i   (clk_i),
    .write_i (push),
    .waddr_i (wptr_q),
    .wdata_i (wr_data_i),
    .read_i  (rd_issue),
    .raddr_i (rptr_q),
    .data_o  (ram_data)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (rd_issue) state_d = ST_PEND;
      ST_PEND:  state_d = ST_VALID;
      ST_VALID: begin
        if (pop) state_d = rd_issue ? ST_PEND : ST_EMPTY;
      end
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    rd_valid_o = (state_q == ST_VALID);
    rd_issue   = ((unread != '0) || push) &&
                 ((state_q == ST_EMPTY) || ((state_q == ST_VALID) && rd_ready_i));
  end

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (push)     wptr_d = wptr_q + 1'b1;
    if (rd_issue) rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (state_q == ST_PEND) rd_data_d = ram_data;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end
endmodule

// File: tb/tb_bram_fifo.sv
// Directed and randomized bench for bram_fifo against a queue-based reference model.
// The model presents a new head word one edge after it becomes the head.

module tb_bram_fifo;
  localparam int MS    = 2;
  localparam int XL    = 32;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [XL-1:0] wr_data_i;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [XL-1:0] rd_data_o;
  logic [MS:0]   count_o;
  logic          full_o;
  logic          empty_o;

  int tests = 0;
  int fails = 0;

  logic [XL-1:0] mq[$];
  logic [XL-1:0] seen[$];
  int            age = 0;

  always #5 clk_i = ~clk_i;

  bram_fifo #(.memSize_p(MS), .XLEN(XL)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_data_i  (wr_data_i),
    .rd_valid_o (rd_valid_o),
    .rd_ready_i (rd_ready_i),
    .rd_data_o  (rd_data_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_vld();
    return (mq.size() > 0) && (age >= 1);
  endfunction

  // One clock: drive, check outputs, advance model, cross the edge.
  task automatic cyc(input bit rst, input bit wv, input logic [XL-1:0] wd, input bit rr);
    bit            push;
    bit            pop;
    bit            was_empty;
    bit            hold;
    logic [XL-1:0] prev;
    reset_i    = rst;
    wr_valid_i = wv;
    wr_data_i  = wd;
    rd_ready_i = rr;
    #1;
    chk("rd_valid", 64'(rd_valid_o), 64'(m_vld()));
    if (m_vld()) chk("rd_data", 64'(rd_data_o), 64'(mq[0]));
    chk("count", 64'(count_o), 64'(mq.size()));
    chk("full", 64'(full_o), 64'(mq.size() == DEPTH));
    chk("empty", 64'(empty_o), 64'(mq.size() == 0));
    chk("wr_ready", 64'(wr_ready_o), 64'(!rst && (mq.size() < DEPTH)));
    hold = !rst && m_vld() && !rr;
    prev = rd_data_o;
    if (rst) begin
      mq.delete();
      age = 0;
    end else begin
      pop       = m_vld() && rr;
      push      = wv && (mq.size() < DEPTH);
      was_empty = (mq.size() == 0);
      if (pop) seen.push_back(mq.pop_front());
      if (push) mq.push_back(wd);
      if (pop || (was_empty && push)) age = 0;
      else if (age < 2) age++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    if (hold) begin
      chk("stall_valid", 64'(rd_valid_o), 64'(1));
      chk("stall_data", 64'(rd_data_o), 64'(prev));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH + 4; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    chk("drained", 64'(count_o), 64'(0));
  endtask

  initial begin
    int            n;
    bit            wv;
    bit            rr;
    logic [XL-1:0] expv;

    reset_i    = 1'b1;
    wr_valid_i = 1'b0;
    wr_data_i  = '0;
    rd_ready_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_rd_valid", 64'(rd_valid_o), 64'(0));
    chk("rst_rd_data", 64'(rd_data_o), 64'(0));
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_full", 64'(full_o), 64'(0));
    chk("rst_count", 64'(count_o), 64'(0));
    reset_i = 1'b0;
    #1;
    chk("rst_wr_ready", 64'(wr_ready_o), 64'(1));

    // Single push, consumer stalled
    cyc(1'b0, 1'b1, 32'hA5A5_0001, 1'b0);
    chk("single_not_yet", 64'(rd_valid_o), 64'(0));
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("single_valid", 64'(rd_valid_o), 64'(1));
    chk("single_data", 64'(rd_data_o), 64'hA5A5_0001);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b0);
    chk("single_count_hold", 64'(count_o), 64'(1));
    drain();

    // Fill to full, reject fifth, drain in order
    seen.delete();
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, XL'(i), 1'b0);
    chk("full_flag", 64'(full_o), 64'(1));
    chk("full_count", 64'(count_o), 64'(4));
    cyc(1'b0, 1'b1, 32'h5, 1'b0);
    chk("fifth_rejected", 64'(count_o), 64'(4));
    drain();
    chk("fill_seen_n", 64'(seen.size()), 64'(4));
    for (int i = 0; i < seen.size(); i++) chk("fill_order", 64'(seen[i]), 64'(i + 1));

    // Pop at full with push offered
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, XL'(32'h21 + i), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 32'h25, 1'b1);
    chk("fullpop_count", 64'(count_o), 64'(3));
    chk("fullpop_ready", 64'(wr_ready_o), 64'(1));
    cyc(1'b0, 1'b1, 32'h25, 1'b0);
    chk("fullpop_push_next", 64'(count_o), 64'(4));
    drain();

    // Streaming across pointer wrap
    seen.delete();
    n = 0;
    for (int i = 0; i < 60; i++) begin
      wv = (mq.size() < 2) && (n < 10);
      cyc(1'b0, wv, XL'(32'h10 + n), 1'b1);
      if (wv) n++;
      chk("stream_cnt_le2", 64'(count_o <= 2), 64'(1));
    end
    chk("stream_seen_n", 64'(seen.size()), 64'(10));
    for (int i = 0; i < seen.size(); i++) chk("stream_order", 64'(seen[i]), 64'(32'h10 + i));

    // Random push/stall traffic
    for (int i = 0; i < 400; i++) begin
      wv   = 1'($urandom_range(1, 0));
      rr   = ($urandom_range(2, 0) != 0);
      expv = $urandom;
      cyc(1'b0, wv, expv, rr);
    end
    drain();

    // Reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, XL'(32'h70 + i), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("pre_rst_count", 64'(count_o), 64'(3));
    cyc(1'b1, 1'b1, 32'h99, 1'b1);
    chk("mid_rst_count", 64'(count_o), 64'(0));
    chk("mid_rst_valid", 64'(rd_valid_o), 64'(0));
    chk("mid_rst_empty", 64'(empty_o), 64'(1));
    cyc(1'b0, 1'b1, 32'h55, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("post_rst_valid", 64'(rd_valid_o), 64'(1));
    chk("post_rst_first", 64'(rd_data_o), 64'h55);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
